// File: rtl/i2c_poll_sequencer.sv
// Round-robin poller for two I2C slaves via the read engine.
// Results are tagged with the slave index and queued in a 4-deep FIFO.
module i2c_poll_sequencer #(
  parameter int POLL_INTERVAL = 1000,
  parameter int TIMEOUT       = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [6:0]  cfg_addr0,
  input  logic [6:0]  cfg_addr1,
  input  logic        clr,
  output logic        start,
  output logic [6:0]  slave_addr,
  input  logic        done,
  input  logic [7:0]  read_data_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_idx,
  output logic        overflow,
  output logic        fault,
  output logic        busy,
  output logic [15:0] round_cnt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_DONE = 3'd2;
  localparam logic [2:0] WAIT_INT  = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;

  localparam int MAXV =
    (TIMEOUT > POLL_INTERVAL) ? TIMEOUT : POLL_INTERVAL;
  localparam int CW = $clog2(MAXV + 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] INT_LOAD = CW'(POLL_INTERVAL - 1);

  logic [2:0]    state, state_n;
  logic          idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          push, timeout_hit, round_done;

  logic [8:0]    mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count, count_n;
  logic          pop, wr_en;

  // One counter serves both the timeout and the interval wait
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    push        = 1'b0;
    timeout_hit = 1'b0;
    round_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          idx_n   = 1'b0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = TO_LOAD;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          push       = 1'b1;
          round_done = idx;
          if (!enable) begin
            state_n = IDLE;
          end else if (!idx) begin
            idx_n   = 1'b1;
            state_n = ISSUE;
          end else begin
            cnt_n   = INT_LOAD;
            state_n = WAIT_INT;
          end
        end else if (cnt == '0) begin
          timeout_hit = 1'b1;
          state_n     = FAULT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAIT_INT: begin
        cnt_n = cnt - 1'b1;
        if (!enable) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          idx_n   = 1'b0;
          state_n = ISSUE;
        end
      end
      FAULT: begin
        if (clr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 1'b0;
      cnt        <= '0;
      start      <= 1'b0;
      slave_addr <= '0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      round_cnt  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      start <= (state_n == ISSUE);
      busy  <= (state_n != IDLE) && (state_n != FAULT);
      if (state_n == ISSUE)
        slave_addr <= idx_n ? cfg_addr1 : cfg_addr0;
      if (round_done)
        round_cnt <= round_cnt + 1'b1;
      if (timeout_hit)
        fault <= 1'b1;
      else if (clr)
        fault <= 1'b0;
    end
  end

  assign pop   = res_valid && res_ready;
  assign wr_en = push && ((count != 3'd4) || pop);

  always_comb begin
    count_n = count;
    if (wr_en && !pop)
      count_n = count + 1'b1;
    else if (pop && !wr_en)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < 4; i++)
        mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {idx, read_data_in};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= count_n;
      res_valid <= (count_n != 3'd0);
      if (push && !wr_en)
        overflow <= 1'b1;
      else if (clr)
        overflow <= 1'b0;
    end
  end

  assign {res_idx, res_data} = mem[rd_ptr];

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Scoreboard bench for i2c_poll_sequencer: engine responses are
// queued as expected FIFO words and compared as the host drains them.
module tb_i2c_poll_sequencer;

  localparam int P = 8;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst, enable, clr, done, res_ready;
  logic [6:0]  cfg_addr0, cfg_addr1, slave_addr;
  logic [7:0]  read_data_in, res_data;
  logic        start, res_valid, res_idx;
  logic        overflow, fault, busy;
  logic [15:0] round_cnt;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic exp_ovf;

  always #5 clk = ~clk;

  i2c_poll_sequencer #(.POLL_INTERVAL(P), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_addr0(cfg_addr0), .cfg_addr1(cfg_addr1), .clr(clr),
    .start(start), .slave_addr(slave_addr), .done(done),
    .read_data_in(read_data_in), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .overflow(overflow), .fault(fault), .busy(busy),
    .round_cnt(round_cnt)
  );

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0; clr = 1'b0; done = 1'b0;
    res_ready = 1'b0; read_data_in = 8'h00;
    cfg_addr0 = 7'h10; cfg_addr1 = 7'h20;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Engine model: answer the pending start after lat cycles.
  task automatic serve(input logic [7:0] data, input int lat,
                       input logic [6:0] addr, input logic idx,
                       input bit pop_too, input bit drop_en);
    int n = 0;
    logic [8:0] w;
    while (start !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    checks++;
    if (start !== 1'b1) begin
      failures++;
      $display("FAIL serve_start got=%b want=1", start);
      return;
    end
    checks++;
    if (slave_addr !== addr) begin
      failures++;
      $display("FAIL serve_addr got=%h want=%h", slave_addr, addr);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b0 || slave_addr !== addr) begin
      failures++;
      $display("FAIL serve_hold start=%b addr=%h want 0/%h",
               start, slave_addr, addr);
    end
    repeat (lat - 1) @(negedge clk);
    done = 1'b1;
    read_data_in = data;
    if (drop_en) enable = 1'b0;
    if (pop_too) begin
      res_ready = 1'b1;
      w = exp_q.pop_front();
      checks++;
      if (res_valid !== 1'b1 || {res_idx, res_data} !== w) begin
        failures++;
        $display("FAIL full_pop got=%b/%h want=1/%h",
                 res_valid, {res_idx, res_data}, w);
      end
    end
    if (exp_q.size() < 4) exp_q.push_back({idx, data});
    else exp_ovf = 1'b1;
    @(negedge clk);
    done = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    logic [8:0] w;
    for (int i = 0; i < n; i++) begin
      w = exp_q.pop_front();
      checks++;
      if (res_valid !== 1'b1 || {res_idx, res_data} !== w) begin
        failures++;
        $display("FAIL drain_%0d got=%b/%h want=1/%h",
                 i, res_valid, {res_idx, res_data}, w);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty got=%b want=0", res_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({start, res_valid, res_idx, overflow, fault, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000",
               {start, res_valid, res_idx, overflow, fault, busy});
    end
    checks++;
    if (slave_addr !== 7'h0 || res_data !== 8'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h want=0/0", slave_addr, res_data);
    end
    checks++;
    if (round_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_round got=%h want=0", round_cnt);
    end
  endtask

  task automatic test_basic();
    int n;
    bit seen;
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_start got=%b/%b want=1/1", start, busy);
    end
    serve(8'hA5, 5, 7'h10, 1'b0, 0, 0);
    checks++;
    if (res_valid !== 1'b1 || start !== 1'b1) begin
      failures++;
      $display("FAIL after_done0 valid=%b start=%b want=1/1",
               res_valid, start);
    end
    serve(8'h3C, 5, 7'h20, 1'b1, 0, 0);
    cfg_addr0 = 7'h15;
    checks++;
    if (round_cnt !== 16'd1) begin
      failures++;
      $display("FAIL round1 got=%0d want=1", round_cnt);
    end
    n = 0;
    while (start !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != P) begin
      failures++;
      $display("FAIL interval got=%0d want=%0d", n, P);
    end
    serve(8'h11, 2, 7'h15, 1'b0, 0, 0);
    serve(8'h22, 3, 7'h20, 1'b1, 0, 0);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL int_drop_busy got=%b want=0", busy);
    end
    seen = 0;
    repeat (P + 4) begin
      @(negedge clk);
      if (start === 1'b1) seen = 1;
    end
    checks++;
    if (seen || round_cnt !== 16'd2) begin
      failures++;
      $display("FAIL int_drop got start=%b round=%0d want 0/2",
               seen, round_cnt);
    end
    drain(4);
  endtask

  task automatic test_backpressure();
    bit seen;
    do_reset();
    enable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      serve(8'(2 * r + 1), 2, 7'h10, 1'b0, 0, 0);
      serve(8'(2 * r + 2), 2, 7'h20, 1'b1, 0, 0);
      if (r == 1) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_at_full got=%b want=0", overflow);
        end
      end
    end
    checks++;
    if (overflow !== exp_ovf || round_cnt !== 16'd3) begin
      failures++;
      $display("FAIL ovf_set got=%b/%0d want=%b/3",
               overflow, round_cnt, exp_ovf);
    end
    serve(8'h07, 2, 7'h10, 1'b0, 1, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (start === 1'b1) seen = 1;
    end
    checks++;
    if (seen || busy !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL done_drop got start=%b busy=%b ovf=%b want 0/0/1",
               seen, busy, overflow);
    end
    drain(4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr got=%b want=0", overflow);
    end
  endtask

  task automatic test_enable_drop();
    bit seen;
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    serve(8'h6D, 3, 7'h10, 1'b0, 0, 0);
    seen = 0;
    repeat (10) begin
      if (start === 1'b1) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen || busy !== 1'b0) begin
      failures++;
      $display("FAIL issue_drop got start=%b busy=%b want 0/0",
               seen, busy);
    end
    drain(1);
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (start !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    for (int i = 1; i <= T + 1; i++) begin
      @(negedge clk);
      if (i == T) begin
        checks++;
        if (fault !== 1'b0) begin
          failures++;
          $display("FAIL fault_early got=%b want=0", fault);
        end
      end
    end
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fault_set got=%b/%b want=1/0", fault, busy);
    end
    done = 1'b1;
    read_data_in = 8'h99;
    @(negedge clk);
    done = 1'b0;
    seen = 0;
    repeat (6) begin
      if (start === 1'b1) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen || res_valid !== 1'b0 || fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_hold start=%b valid=%b fault=%b want 0/0/1",
               seen, res_valid, fault);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_clr got=%b want=0", fault);
    end
    serve(8'h5A, T, 7'h10, 1'b0, 0, 1);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL last_cycle_done fault=%b want=0", fault);
    end
    drain(1);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    enable = 1'b1;
    serve(8'h41, 1, 7'h10, 1'b0, 0, 0);
    serve(8'h42, 1, 7'h20, 1'b1, 0, 0);
    n = 0;
    while (start !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got=%b/%b want=1/1", res_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({start, res_valid, res_idx, overflow, fault, busy} !== 6'b0
        || slave_addr !== 7'h0 || res_data !== 8'h0
        || round_cnt !== 16'h0) begin
      failures++;
      $display("FAIL async_reset flags=%b addr=%h data=%h round=%h",
               {start, res_valid, res_idx, overflow, fault, busy},
               slave_addr, res_data, round_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    exp_q.delete();
    done = 1'b1;
    read_data_in = 8'h77;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || start !== 1'b0) begin
      failures++;
      $display("FAIL late_done valid=%b busy=%b start=%b want 0/0/0",
               res_valid, busy, start);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_drop();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_poll_sequencer.md
# i2c_poll_sequencer

Upstream sequencer for the I2C read engine. Repeatedly polls two configurable slaves by issuing `start`/`slave_addr` to the read engine and waiting for its `done` pulse. Each returned byte is tagged with its slave index and pushed into a 4-entry result FIFO drained by the host over a valid/ready handshake. Adds a configurable inter-round interval, a per-transaction timeout with a sticky fault, and FIFO overflow detection.

## Interface
- `POLL_INTERVAL`, default 1000: idle cycles between polling rounds (≥1).
- `TIMEOUT`, default 65535: maximum cycles from `start` to `done` (≥2).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: polling enable, level.
- `cfg_addr0` in 7: slave 0 address, sampled at each ISSUE.
- `cfg_addr1` in 7: slave 1 address, sampled at each ISSUE.
- `clr` in 1: single-cycle pulse; clears `overflow` and `fault`, returns FAULT to IDLE.
- `start` out 1: one-cycle request to the read engine.
- `slave_addr` out 7: target address, held stable from ISSUE through WAIT_DONE.
- `done` in 1: one-cycle completion pulse from the read engine.
- `read_data_in` in 8: read byte, valid in the `done` cycle.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: host accepts the head.
- `res_data` out 8: head data byte.
- `res_idx` out 1: head slave index.
- `overflow` out 1: sticky; a result was dropped because the FIFO was full.
- `fault` out 1: sticky; a timeout occurred.
- `busy` out 1: state is not IDLE and not FAULT.
- `round_cnt` out 16: completed rounds, wraps 0xFFFF→0.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, WAIT_INT, FAULT. Register `idx` (1 bit) selects the slave.
- IDLE: when `enable`=1, set `idx`=0 and go to ISSUE.
- ISSUE (exactly one cycle):
  - `start`=1, `slave_addr`=`idx`?`cfg_addr1`:`cfg_addr0`.
  - Load the timeout counter with `TIMEOUT`-1 and go to WAIT_DONE.
- WAIT_DONE: `start`=0 and `slave_addr` holds.
  - On `done`=1: push {`idx`, `read_data_in`} into the FIFO.
    - If `idx`=0: set `idx`=1 and go to ISSUE.
    - If `idx`=1: increment `round_cnt`. If `enable`=1, load the interval counter with `POLL_INTERVAL`-1 and go to WAIT_INT; otherwise go to IDLE.
  - Otherwise, if the counter is 0: set `fault`=1 and go to FAULT (no FIFO push). Else decrement the counter.
- WAIT_INT: decrement each cycle.
  - `enable`=0 → IDLE immediately.
  - Counter 0 with `enable`=1 → `idx`=0, ISSUE.
- FAULT: stays until `clr` → IDLE. `done` is ignored in FAULT.
- `enable` deasserted during ISSUE/WAIT_DONE: the current slave transaction completes and is stored, then go to IDLE (no further ISSUE).
- FIFO: 4 entries, 2-bit read/write pointers wrapping 3→0, 3-bit count 0..4.
  - `res_valid` = (count≠0). `res_data`/`res_idx` show the head (show-ahead).
  - Pop when `res_valid` && `res_ready`.
  - Push when count<4, or when count=4 and a pop occurs in the same cycle.
  - Push at count=4 without a pop: the entry is dropped and `overflow`←1.
  - Push and pop in the same cycle at count 1..3: count is unchanged.
- `clr` in the same cycle as a new overflow or timeout: the set wins.
- `done` outside WAIT_DONE is ignored.

## Timing
- Reset values:
  - `start`=0, `slave_addr`=0, `res_valid`=0, `res_data`=0, `res_idx`=0.
  - `overflow`=0, `fault`=0, `busy`=0, `round_cnt`=0.
  - State IDLE, FIFO empty.
- Reset mid-operation: all of the above apply immediately; FIFO contents are discarded.
- All outputs are registered.
- `enable` sampled 1 in IDLE at edge k → `start`=1 during cycle k+1 to k+2.
- `done` at edge d:
  - `res_valid`=1 from d+1 if the FIFO was empty.
  - Next `start` (idx 1) is high in cycle d+1..d+2.
- Round end (`done` for idx 1 at edge d): next idx-0 `start` rises at edge d+1+`POLL_INTERVAL`.
- Timeout: `start` rises at edge s, no `done` → `fault`=1 from edge s+1+`TIMEOUT`.
- A `done` at exactly the last counter cycle is accepted (done has priority over timeout).
- Pop at edge p: the new head is visible after p. Push-to-`res_valid` latency is 1 cycle.

## Test plan
- Basic round: `cfg_addr0`=0x10, `cfg_addr1`=0x20, `enable`=1, engine model returns 0xA5 then 0x3C after 5 cycles each → two `start` pulses with addresses 0x10 and 0x20; FIFO entries {0,0xA5},{1,0x3C}; `round_cnt`=1; next start after exactly `POLL_INTERVAL` cycles.
- Backpressure/overflow: `res_ready`=0 for 3 rounds (6 results) → FIFO holds the first 4 in order, `overflow`=1; simultaneous push and pop at full in a later cycle is accepted with count staying 4; `clr` → `overflow`=0.
- Timeout: `TIMEOUT`=16, engine never asserts `done` → `fault`=1 exactly 17 cycles after the `start` edge, `busy`=0, no further `start`; `clr` then `enable`=1 → a new round starts.
- Enable drop: deassert `enable` during WAIT_DONE of idx 0 → the idx-0 result is stored, no idx-1 `start`, returns to IDLE; deassert in WAIT_INT → IDLE next cycle.
- Async reset mid-WAIT_DONE with 2 FIFO entries → all outputs at reset values immediately; a late `done` after reset is ignored.
- `round_cnt` wrap: preload via 65536 rounds at `POLL_INTERVAL`=1 → counter returns to 0.
